multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised main control FSM for the multicycle RV32I core, successor to the fixed-latency controller. Drives the same datapath control lines (PC/IR/register/memory write enables, ALU operand and result selects), and adds a ready-based memory handshake with a configurable timeout. It also supports an optional multi-cycle M-extension wait path and precise traps for illegal instructions and bus errors. It sits between the instruction register decode fields and the shared-memory datapath.

## Interface
- ENABLE_M, 1: decode R-type funct7=0000001 as MUL/DIV via the MULDIV state; when 0, that funct7 is illegal.
- TRAP_ON_ILLEGAL, 1: illegal encodings enter TRAP; when 0, they return to FETCH as a NOP.
- MEM_TIMEOUT, 255: wait-cycle limit per memory request; 0 disables the timeout. Range 0..65535.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero, blt, bge, bltu, bgeu  in  1 each  ALU compare flags
- mem_ready  in  1  memory completes the current request this cycle
- muldiv_done  in  1  M-unit result valid
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables/selects
- ResultSrc, ALUSrcA, ALUSrcB, alu_op  out  2 each. alu_op encoding: 00 add, 01 sub/compare, 10 funct-decoded, 11 pass B.
- mem_req  out  1  memory request valid
- muldiv_start  out  1  one-cycle M-unit start pulse
- trap  out  1  one-cycle pulse; datapath loads PC from the trap vector
- trap_cause  out  2  00 illegal, 01 fetch bus error, 10 load bus error, 11 store bus error; holds until the next trap

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MULDIV, MD_WB, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JAL, JALR, LINK, TRAP.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCWrite are asserted only in the cycle mem_ready=1, and the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, alu_op=00. This latches oldPC+imm into ALUOut.
- DECODE transitions:
  - R-type → EXEC_R, or MULDIV when ENABLE_M=1 and funct7=0000001.
  - I-ALU and LUI → EXEC_I. LUI uses alu_op=11; I-ALU uses alu_op=10.
  - Load/store → MEM_ADDR. B-type → BRANCH. JAL → JAL. JALR → JALR. AUIPC → ALU_WB.
- Illegal encodings: unknown opcode, B-type funct3 010/011, R-type funct7 outside {0000000, 0100000, 0000001 when ENABLE_M}. These go to TRAP with cause 00, or to FETCH when TRAP_ON_ILLEGAL=0.
- EXEC_R (A=10, B=00, alu_op=10) and EXEC_I (A=10, B=01) → ALU_WB.
- ALU_WB: ResultSrc=00, RegWrite=1 → FETCH.
- MULDIV: muldiv_start=1 on the entry cycle only. Waits until muldiv_done=1, then → MD_WB.
- MD_WB: ResultSrc=11, RegWrite=1 → FETCH.
- MEM_ADDR: A=10, B=01, alu_op=00. Goes to MEM_WRITE for stores, MEM_READ for loads.
- MEM_READ: mem_req=1, AdrSrc=1. On mem_ready → MEM_WB.
- MEM_WB: ResultSrc=01, RegWrite=1 → FETCH.
- MEM_WRITE: mem_req=1, AdrSrc=1, MemWrite=1. On mem_ready → FETCH.
- BRANCH: A=10, B=00, alu_op=01, ResultSrc=00. PCWrite is set per funct3: beq→zero, bne→~zero, blt, bge, bltu, bgeu. Then → FETCH.
- JAL: PCWrite=1, ResultSrc=00 (target from DECODE). In the same cycle A=01, B=10, alu_op=00 computes oldPC+4. → ALU_WB.
- JALR: A=10, B=01, alu_op=00, ResultSrc=10, PCWrite=1 → LINK.
- LINK: A=01, B=10, alu_op=00 → ALU_WB.
- TRAP: trap=1, PCWrite=1, mem_req=0. trap_cause is updated on entry. → FETCH.
- Timeout counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments on each cycle with mem_req=1 and mem_ready=0.
  - When MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT with mem_ready=0, the FSM goes to TRAP with cause 01, 10 or 11 according to the current state.
  - No write enable is asserted in that cycle.
  - mem_ready=1 on the limit cycle wins; the access completes normally.
- All outputs not listed for a state are 0.

## Timing
- Reset asserted: state=FETCH, counter=0, trap_cause=00. PCWrite, IRWrite, RegWrite, MemWrite, mem_req, muldiv_start and trap are all forced 0 while rst=0, including when reset is asserted mid-access.
- The first mem_req is issued in the first cycle after reset release.
- Zero-wait-state cycle counts:
  - ALU ops: 4. LUI/AUIPC: 4 / 3. Loads: 5. Stores: 4. Branches: 3. JAL: 4. JALR: 5.
  - Each wait cycle adds 1 to the count.
- MULDIV latency is 2 + N cycles to writeback, where N is the number of cycles muldiv_done is low. muldiv_done high on the entry cycle gives N=0.
- All outputs are combinational from state and inputs. State, counter and trap_cause are registered.

## Test plan
- Reset release with mem_ready held 1, add x3,x1,x2 → mem_req at cycle 1, IRWrite+PCWrite at cycle 1, RegWrite at cycle 4.
- Fetch with mem_ready low 3 cycles → FETCH held 4 cycles, IRWrite exactly once on the ready cycle.
- Load with MEM_TIMEOUT=4 and mem_ready never asserted → trap=1 for one cycle after 4 wait cycles, trap_cause=10, no RegWrite.
- mul (funct7=0000001) with muldiv_done after 5 cycles, ENABLE_M=1 → one muldiv_start pulse, MD_WB with ResultSrc=11. Same instruction with ENABLE_M=0 → trap_cause=00.
- Branch sweep: beq with zero=1 → PCWrite=1; bne with zero=1 → 0; bltu with bltu=1 → 1; funct3=010 → TRAP.
- rst pulled low during MEM_WRITE wait → MemWrite and mem_req drop immediately, FSM in FETCH at release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core. Provides a ready-based memory
// handshake with a wait-cycle timeout, an optional M-extension wait path and precise traps.
module multicycle_ctrl #(
  parameter bit          ENABLE_M        = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       blt,
  input  logic       bge,
  input  logic       bltu,
  input  logic       bgeu,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] alu_op,
  output logic       mem_req,
  output logic       muldiv_start,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int unsigned CNT_W = 16;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [1:0] CAUSE_ILL = 2'b00;
  localparam logic [1:0] CAUSE_IF  = 2'b01;
  localparam logic [1:0] CAUSE_LD  = 2'b10;
  localparam logic [1:0] CAUSE_ST  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MULDIV, S_MD_WB, S_ALU_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_LINK, S_TRAP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [1:0]       cause_q, cause_next;
  logic             md_busy;
  logic             in_mem, tmo_hit, md_op, f7_legal, illegal, br_take;

  assign in_mem   = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign tmo_hit  = (MEM_TIMEOUT != 0) && in_mem && !mem_ready &&
                    (wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign md_op    = ENABLE_M && (funct7 == 7'b0000001);
  assign f7_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) || md_op;
  assign trap_cause = cause_q;

  // Encodings that cannot be executed
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R:    illegal = !f7_legal;
      OP_BR:   illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = zero;
      3'b001:  br_take = !zero;
      3'b100:  br_take = blt;
      3'b101:  br_take = bge;
      3'b110:  br_take = bltu;
      3'b111:  br_take = bgeu;
      default: br_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= CAUSE_ILL;
      md_busy  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      cause_q  <= cause_next;
      md_busy  <= (state == S_MULDIV);
    end
  end

  always_comb begin
    state_next    = state;
    cause_next    = cause_q;
    wait_cnt_next = wait_cnt;
    case (state)
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
        else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_IF;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          if (TRAP_ON_ILLEGAL) cause_next = CAUSE_ILL;
        end else begin
          case (opcode)
            OP_R:             state_next = md_op ? S_MULDIV : S_EXEC_R;
            OP_I, OP_LUI:     state_next = S_EXEC_I;
            OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
            OP_BR:            state_next = S_BRANCH;
            OP_JAL:           state_next = S_JAL;
            OP_JALR:          state_next = S_JALR;
            OP_AUIPC:         state_next = S_ALU_WB;
            default:          state_next = S_FETCH;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I, S_JAL, S_LINK: state_next = (state == S_JAL || state == S_LINK ||
                                                       state == S_EXEC_R || state == S_EXEC_I)
                                                      ? S_ALU_WB : S_FETCH;
      S_MULDIV:   if (muldiv_done) state_next = S_MD_WB;
      S_MEM_ADDR: state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready) state_next = S_MEM_WB;
        else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_LD;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) state_next = S_FETCH;
        else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ST;
        end
      end
      S_JALR:  state_next = S_LINK;
      default: state_next = S_FETCH;
    endcase
    // Counter restarts on every state change, so each request starts from zero
    if (state_next != state) wait_cnt_next = '0;
    else if (in_mem && !mem_ready) wait_cnt_next = wait_cnt + CNT_W'(1);
  end

  always_comb begin
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    alu_op       = 2'b00;
    mem_req      = 1'b0;
    muldiv_start = 1'b0;
    trap         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = (opcode == OP_LUI) ? 2'b11 : 2'b10;
      end
      S_ALU_WB: RegWrite = 1'b1;
      S_MULDIV: muldiv_start = !md_busy;
      S_MD_WB: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEM_WB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = !tmo_hit;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        PCWrite = br_take;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_TRAP: begin
        trap    = 1'b1;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Enables and strobes are held off while reset is asserted
    if (!rst) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      mem_req      = 1'b0;
      muldiv_start = 1'b0;
      trap         = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction into
// its expected per-cycle control vectors, which are then applied and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam logic [2:0]  EN_T  = 3'b101;
  localparam logic [2:0]  TI_T  = 3'b011;
  localparam logic [47:0] TMO_T = {16'd255, 16'd0, 16'd4};

  localparam logic [17:0] M_ALL = 18'h3ffff;
  localparam logic [17:0] M_RST = 18'b1111_0_00_00_00_00_111_11;
  localparam logic [3:0]  E_NO = 4'b0000, E_PC = 4'b1000, E_IR = 4'b0100;
  localparam logic [3:0]  E_RW = 4'b0010, E_MW = 4'b0001;
  localparam logic [2:0]  Q_NO = 3'b000, Q_REQ = 3'b100, Q_ST = 3'b010, Q_TR = 3'b001;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  typedef enum int {K_ALU_R, K_MD, K_ALU_I, K_LUI, K_AUIPC, K_LOAD, K_STORE,
                    K_BR, K_JAL, K_JALR, K_ILL} kind_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic        r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  fl;
    logic        rdy;
    logic        mdd;
    logic [17:0] want;
    logic [17:0] mask;
  } vec_t;

  logic        clk, rst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        zero, blt, bge, bltu, bgeu, mem_ready, muldiv_done;
  logic [17:0] obus [3];

  vec_t        vq[$];
  int          n_vec, n_bad, budget, p_tmo;
  logic [1:0]  cur_sel, exp_cause;
  logic [6:0]  cur_op, cur_f7;
  logic [2:0]  cur_f3;
  logic [4:0]  cur_fl;
  logic        rdy_idle, p_en, p_til;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pcw, irw, rw, mw, adr, req, st, tr;
    logic [1:0] rs, a, b, op, tc;
    multicycle_ctrl #(
      .ENABLE_M(EN_T[g]), .TRAP_ON_ILLEGAL(TI_T[g]), .MEM_TIMEOUT(32'(TMO_T[g*16 +: 16]))
    ) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zero(zero), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu),
      .mem_ready(mem_ready), .muldiv_done(muldiv_done),
      .PCWrite(pcw), .IRWrite(irw), .RegWrite(rw), .MemWrite(mw), .AdrSrc(adr),
      .ResultSrc(rs), .ALUSrcA(a), .ALUSrcB(b), .alu_op(op),
      .mem_req(req), .muldiv_start(st), .trap(tr), .trap_cause(tc)
    );
    assign obus[g] = {pcw, irw, rw, mw, adr, rs, a, b, op, req, st, tr, tc};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ov(input logic [3:0] en, input logic adr, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [2:0] q);
    return {en, adr, rs, a, b, op, q, exp_cause};
  endfunction

  function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7);
    case (op)
      OP_R: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) return K_ALU_R;
        if (f7 == 7'b0000001 && p_en) return K_MD;
        return K_ILL;
      end
      OP_I:     return K_ALU_I;
      OP_LUI:   return K_LUI;
      OP_AUIPC: return K_AUIPC;
      OP_LOAD:  return K_LOAD;
      OP_STORE: return K_STORE;
      OP_BR:    return (f3 == 3'b010 || f3 == 3'b011) ? K_ILL : K_BR;
      OP_JAL:   return K_JAL;
      OP_JALR:  return K_JALR;
      default:  return K_ILL;
    endcase
  endfunction

  // fl = {zero, blt, bge, bltu, bgeu}
  function automatic logic br_outcome(input logic [2:0] f3, input logic [4:0] fl);
    case (f3)
      3'b000:  return fl[4];
      3'b001:  return !fl[4];
      3'b100:  return fl[3];
      3'b101:  return fl[2];
      3'b110:  return fl[1];
      3'b111:  return fl[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic r, input logic rdy, input logic mdd,
                      input logic [17:0] want, input logic [17:0] mask);
    vec_t v;
    if (budget == 0) return;
    if (budget > 0) budget--;
    v = '{sel: cur_sel, r: r, op: cur_op, f3: cur_f3, f7: cur_f7, fl: cur_fl,
          rdy: rdy, mdd: mdd, want: want, mask: mask};
    vq.push_back(v);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_vec(input string name, input logic [17:0] got, input logic [17:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic select_dut(input int s);
    cur_sel = 2'(s);
    p_en    = EN_T[s];
    p_til   = TI_T[s];
    p_tmo   = int'(TMO_T[s*16 +: 16]);
  endtask

  task automatic push_reset(input int n);
    exp_cause = 2'b00;
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, ov(E_NO, 0, 0, 0, 0, 0, Q_NO), M_RST);
  endtask

  task automatic trap_seq(input logic [1:0] c);
    exp_cause = c;
    push(1'b1, rdy_idle, 1'b0, ov(E_PC, 0, 0, 0, 0, 0, Q_TR), M_ALL);
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic mem_phase(input int kind, input int waits, output bit timed_out);
    logic [3:0] en_w;
    logic [1:0] rs, b;
    logic       adr;
    en_w = (kind == 2) ? E_MW : E_NO;
    adr  = (kind != 0);
    rs   = (kind == 0) ? 2'b10 : 2'b00;
    b    = (kind == 0) ? 2'b10 : 2'b00;
    timed_out = 1'b0;
    for (int w = 0; w < waits; w++) begin
      if (p_tmo != 0 && w == p_tmo) begin
        push(1'b1, 1'b0, 1'b0, ov(E_NO, adr, rs, 2'b00, b, 2'b00, Q_REQ), M_ALL);
        timed_out = 1'b1;
        trap_seq(kind == 0 ? 2'b01 : (kind == 1 ? 2'b10 : 2'b11));
        return;
      end
      push(1'b1, 1'b0, 1'b0, ov(en_w, adr, rs, 2'b00, b, 2'b00, Q_REQ), M_ALL);
    end
    push(1'b1, 1'b1, 1'b0, ov(kind == 0 ? (E_PC | E_IR) : en_w, adr, rs, 2'b00, b, 2'b00, Q_REQ),
         M_ALL);
  endtask

  task automatic wb_alu();
    push(1'b1, rdy_idle, 1'b0, ov(E_RW, 0, 2'b00, 2'b00, 2'b00, 2'b00, Q_NO), M_ALL);
  endtask

  // Expands one instruction into its expected cycle sequence
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] fl, input int fw, input int mw, input int mdw);
    bit to;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_fl = fl;
    mem_phase(0, fw, to);
    if (to) return;
    push(1'b1, rdy_idle, 1'b0, ov(E_NO, 0, 2'b00, 2'b01, 2'b01, 2'b00, Q_NO), M_ALL);
    case (classify(op, f3, f7))
      K_ALU_R: begin
        push(1'b1, rdy_idle, 1'b0, ov(E_NO, 0, 2'b00, 2'b10, 2'b00, 2'b10, Q_NO), M_ALL);
        wb_alu();
      end
      K_MD: begin
        for (int i = 0; i <= mdw; i++)
          push(1'b1, rdy_idle, (i == mdw), ov(E_NO, 0, 0, 0, 0, 0, (i == 0) ? Q_ST : Q_NO), M_ALL);
        push(1'b1, rdy_idle, 1'b0, ov(E_RW, 0, 2'b11, 2'b00, 2'b00, 2'b00, Q_NO), M_ALL);
      end
      K_ALU_I, K_LUI: begin
        push(1'b1, rdy_idle, 1'b0, ov(E_NO, 0, 2'b00, 2'b10, 2'b01,
             (op == OP_LUI) ? 2'b11 : 2'b10, Q_NO), M_ALL);
        wb_alu();
      end
      K_AUIPC: wb_alu();
      K_LOAD, K_STORE: begin
        push(1'b1, rdy_idle, 1'b0, ov(E_NO, 0, 2'b00, 2'b10, 2'b01, 2'b00, Q_NO), M_ALL);
        mem_phase((op == OP_STORE) ? 2 : 1, mw, to);
        if (!to && op == OP_LOAD)
          push(1'b1, rdy_idle, 1'b0, ov(E_RW, 0, 2'b01, 2'b00, 2'b00, 2'b00, Q_NO), M_ALL);
      end
      K_BR: push(1'b1, rdy_idle, 1'b0, ov(br_outcome(f3, fl) ? E_PC : E_NO, 0, 2'b00, 2'b10,
                 2'b00, 2'b01, Q_NO), M_ALL);
      K_JAL: begin
        push(1'b1, rdy_idle, 1'b0, ov(E_PC, 0, 2'b00, 2'b01, 2'b10, 2'b00, Q_NO), M_ALL);
        wb_alu();
      end
      K_JALR: begin
        push(1'b1, rdy_idle, 1'b0, ov(E_PC, 0, 2'b10, 2'b10, 2'b01, 2'b00, Q_NO), M_ALL);
        push(1'b1, rdy_idle, 1'b0, ov(E_NO, 0, 2'b00, 2'b01, 2'b10, 2'b00, Q_NO), M_ALL);
        wb_alu();
      end
      default: if (p_til) trap_seq(2'b00);
    endcase
  endtask

  task automatic run_len(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] fl, input int want);
    int n0;
    n0 = vq.size();
    run_instr(op, f3, 7'b0000000, fl, 0, 0, 0);
    chk_int(name, vq.size() - n0, want);
  endtask

  initial begin
    int   n0;
    vec_t v;
    logic [17:0] act;
    n_vec = 0; n_bad = 0; budget = -1;
    rst = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    {zero, blt, bge, bltu, bgeu} = 5'b0; mem_ready = 1'b0; muldiv_done = 1'b0;
    exp_cause = 2'b00; rdy_idle = 1'b0;
    cur_op = '0; cur_f3 = '0; cur_f7 = '0; cur_fl = '0;

    // Instance 0: M enabled, trapping, timeout 4
    select_dut(0);
    push_reset(2);
    rdy_idle = 1'b1;
    n0 = vq.size();
    run_instr(OP_R, 3'b000, 7'b0000000, 5'b0, 0, 0, 0);
    chk_int("add_cycles", vq.size() - n0, 4);
    chk_vec("add_wb_vector", vq[n0 + 3].want, 18'h08000);
    rdy_idle = 1'b0;
    run_instr(OP_I, 3'b000, 7'b0, 5'b0, 3, 0, 0);
    run_len("lui_cycles", OP_LUI, 3'b000, 5'b0, 4);
    run_len("auipc_cycles", OP_AUIPC, 3'b000, 5'b0, 3);
    run_len("lw_cycles", OP_LOAD, 3'b010, 5'b0, 5);
    run_len("sw_cycles", OP_STORE, 3'b010, 5'b0, 4);
    run_len("beq_cycles", OP_BR, 3'b000, 5'b0, 3);
    run_len("jal_cycles", OP_JAL, 3'b000, 5'b0, 4);
    run_len("jalr_cycles", OP_JALR, 3'b000, 5'b0, 5);
    n0 = vq.size();
    run_instr(OP_LOAD, 3'b010, 7'b0, 5'b0, 0, 10, 0);
    chk_int("lw_timeout_cycles", vq.size() - n0, 9);
    chk_vec("lw_timeout_trap", vq[vq.size() - 1].want, 18'h20006);
    n0 = vq.size();
    run_instr(OP_R, 3'b000, 7'b0000001, 5'b0, 0, 0, 5);
    chk_int("mul_cycles", vq.size() - n0, 9);
    run_instr(OP_BR, 3'b000, 7'b0, 5'b10000, 0, 0, 0);
    run_instr(OP_BR, 3'b001, 7'b0, 5'b10000, 0, 0, 0);
    run_instr(OP_BR, 3'b110, 7'b0, 5'b00010, 0, 0, 0);
    run_instr(OP_BR, 3'b101, 7'b0, 5'b00100, 0, 0, 0);
    run_instr(OP_BR, 3'b100, 7'b0, 5'b01011, 0, 0, 0);
    run_instr(OP_BR, 3'b010, 7'b0, 5'b11111, 0, 0, 0);
    run_instr(OP_STORE, 3'b010, 7'b0, 5'b0, 0, 2, 0);
    run_instr(OP_STORE, 3'b010, 7'b0, 5'b0, 0, 4, 0);
    run_instr(OP_R, 3'b000, 7'b0, 5'b0, 6, 0, 0);
    run_instr(OP_STORE, 3'b010, 7'b0, 5'b0, 0, 9, 0);
    run_instr(7'b1111111, 3'b000, 7'b0, 5'b0, 0, 0, 0);
    run_instr(OP_R, 3'b000, 7'b0100000, 5'b0, 0, 0, 0);
    run_instr(OP_R, 3'b000, 7'b0000010, 5'b0, 0, 0, 0);
    budget = 5;
    run_instr(OP_STORE, 3'b010, 7'b0, 5'b0, 0, 5, 0);
    budget = -1;
    push_reset(2);
    run_instr(OP_R, 3'b000, 7'b0, 5'b0, 0, 0, 0);

    // Instance 1: M disabled, trapping, no timeout
    select_dut(1);
    push_reset(2);
    run_instr(OP_R, 3'b000, 7'b0000001, 5'b0, 0, 0, 0);
    run_instr(OP_R, 3'b000, 7'b0, 5'b0, 8, 0, 0);
    run_instr(OP_LOAD, 3'b010, 7'b0, 5'b0, 0, 7, 0);

    // Instance 2: M enabled, illegal as NOP, default timeout
    select_dut(2);
    push_reset(2);
    run_instr(OP_R, 3'b100, 7'b0000001, 5'b0, 0, 0, 0);
    run_instr(7'b0000000, 3'b000, 7'b0, 5'b0, 0, 0, 0);
    run_instr(OP_JALR, 3'b000, 7'b0, 5'b0, 1, 0, 0);
    run_instr(OP_LOAD, 3'b010, 7'b0, 5'b0, 3, 3, 0);
    run_instr(OP_BR, 3'b111, 7'b0, 5'b00001, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      rst = v.r; opcode = v.op; funct3 = v.f3; funct7 = v.f7;
      {zero, blt, bge, bltu, bgeu} = v.fl;
      mem_ready = v.rdy; muldiv_done = v.mdd;
      #2;
      act = obus[v.sel];
      n_vec++;
      if ((act & v.mask) !== (v.want & v.mask)) begin
        n_bad++;
        $display("FAIL cycle %0d dut %0d: got %b required %b (mask %b)",
                 i, v.sel, act, v.want, v.mask);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
